// File: rtl/jpeg_merge_pkg.sv
// Shared types and default widths for the JPEG bitstream merger.
// Overflow flags are built only when JPEG_MERGE_OVF_EN is defined.
package jpeg_merge_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ORC_W_DEF  = 5;

  typedef enum logic {
    S_WAIT,
    S_SEND
  } merge_state_t;

  typedef struct packed {
    logic                 eob;
    logic [ORC_W_DEF-1:0]  orc;
    logic [DATA_W_DEF-1:0] data;
  } merge_entry_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jpeg_ch_fifo.sv
// Per-channel word FIFO for the JPEG bitstream merger.
// Registered pointers, no read bypass.
module jpeg_ch_fifo
  import jpeg_merge_pkg::*;
#(
  parameter int W     = $bits(merge_entry_t),
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/jpeg_stream_merger.sv
// Buffers NUM_CH encoder word streams and re-serialises them block by block.
// Define JPEG_MERGE_OVF_EN to build the sticky per-channel overflow flags.
module jpeg_stream_merger
  import jpeg_merge_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ORC_W  = ORC_W_DEF,
  parameter int DEPTH  = 16,
  localparam int CH_W  = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH*ORC_W-1:0]  ch_orc,
  input  logic [NUM_CH-1:0]        ch_eob,
  output logic [NUM_CH-1:0]        ch_full,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ORC_W-1:0]         out_orc,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_eob,
  output logic [NUM_CH-1:0]        ovf_flag
);

  localparam int EW = DATA_W + ORC_W + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [EW-1:0]     head [NUM_CH];
  logic [CW-1:0]     cnt  [NUM_CH];
  logic [NUM_CH-1:0] f_full;
  logic [NUM_CH-1:0] f_empty;
  logic [NUM_CH-1:0] pop;

  merge_state_t      state;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   next_ch;
  logic [EW-1:0]     cur_head;
  logic              cur_empty;
  logic              load;
  logic              take;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    jpeg_ch_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ch_valid[g]),
      .pop   (pop[g]),
      .din   ({ch_eob[g],
               ch_orc[g*ORC_W +: ORC_W],
               ch_data[g*DATA_W +: DATA_W]}),
      .dout  (head[g]),
      .full  (f_full[g]),
      .empty (f_empty[g]),
      .count (cnt[g])
    );
    assign ch_full[g] = (cnt[g] == CW'(DEPTH));
  end

  always_comb begin
    cur_head  = '0;
    cur_empty = 1'b1;
    pop       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_ch == CH_W'(i)) begin
        cur_head  = head[i];
        cur_empty = f_empty[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = take && (cur_ch == CH_W'(i));
    end
  end

  // out_valid mirrors S_SEND, so the state alone decides the load slot
  assign load    = (state == S_WAIT) | out_ready;
  assign take    = load & ~cur_empty;
  assign next_ch = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_WAIT;
      cur_ch    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_orc   <= '0;
      out_ch    <= '0;
      out_eob   <= 1'b0;
    end else if (load) begin
      if (take) begin
        state     <= S_SEND;
        out_valid <= 1'b1;
        out_data  <= cur_head[DATA_W-1:0];
        out_orc   <= cur_head[DATA_W +: ORC_W];
        out_eob   <= cur_head[EW-1];
        out_ch    <= cur_ch;
        if (cur_head[EW-1]) cur_ch <= next_ch;
      end else begin
        state     <= S_WAIT;
        out_valid <= 1'b0;
      end
    end
  end

`ifdef JPEG_MERGE_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_flag <= '0;
    else      ovf_flag <= ovf_flag | (ch_valid & f_full);
  end
`else
  assign ovf_flag = '0;
`endif

endmodule

// File: tb/tb_jpeg_stream_merger.sv
// Directed bench for jpeg_stream_merger (3-channel and 1-channel builds).
// Expected ovf_flag follows JPEG_MERGE_OVF_EN.
module tb_jpeg_stream_merger;

`ifdef JPEG_MERGE_OVF_EN
  localparam logic [2:0] OVF_EXP = 3'b010;
`else
  localparam logic [2:0] OVF_EXP = 3'b000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [2:0]  ch_valid = '0;
  logic [95:0] ch_data  = '0;
  logic [14:0] ch_orc   = '0;
  logic [2:0]  ch_eob   = '0;
  logic [2:0]  ch_full;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_orc;
  logic [1:0]  out_ch;
  logic        out_eob;
  logic [2:0]  ovf_flag;

  logic        v1 = 1'b0;
  logic [31:0] d1 = '0;
  logic [4:0]  o1 = '0;
  logic        e1 = 1'b0;
  logic        full1;
  logic        v1o;
  logic        r1 = 1'b0;
  logic [31:0] od1;
  logic [4:0]  oo1;
  logic        och1;
  logic        oe1;
  logic        ovf1;

  int checks = 0;
  int errors = 0;

  logic [34:0] q[$];
  logic [31:0] q1[$];
  int          ch_bad  = 0;
  int          run     = 0;
  int          max_run = 0;

  always #5 clk = ~clk;

  jpeg_stream_merger #(.NUM_CH(3), .DEPTH(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_orc    (ch_orc),
    .ch_eob    (ch_eob),
    .ch_full   (ch_full),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_orc   (out_orc),
    .out_ch    (out_ch),
    .out_eob   (out_eob),
    .ovf_flag  (ovf_flag)
  );

  jpeg_stream_merger #(.NUM_CH(1), .DEPTH(16)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .ch_valid  (v1),
    .ch_data   (d1),
    .ch_orc    (o1),
    .ch_eob    (e1),
    .ch_full   (full1),
    .out_valid (v1o),
    .out_ready (r1),
    .out_data  (od1),
    .out_orc   (oo1),
    .out_ch    (och1),
    .out_eob   (oe1),
    .ovf_flag  (ovf1)
  );

  always @(posedge clk) begin
    if (rst && out_valid && out_ready)
      q.push_back({out_ch, out_eob, out_data});
  end

  always @(posedge clk) begin
    if (rst) begin
      if (v1o && r1) begin
        q1.push_back(od1);
        if (och1 != 1'b0) ch_bad++;
      end
      if (v1o) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    ch_valid  = '0;
    ch_eob    = '0;
    out_ready = 1'b0;
    v1        = 1'b0;
    r1        = 1'b0;
    repeat (2) step();
    q.delete();
    rst = 1'b1;
    step();
  endtask

  task automatic push(input int ch, input logic [31:0] data,
                      input logic eob);
    ch_valid              = '0;
    ch_eob                = '0;
    ch_valid[ch]          = 1'b1;
    ch_eob[ch]            = eob;
    ch_data[ch*32 +: 32]  = data;
    ch_orc[ch*5 +: 5]     = data[4:0];
    step();
    ch_valid = '0;
    ch_eob   = '0;
  endtask

  initial begin
    do_reset();
    check("rst_out", {out_valid, out_eob, out_ch, out_orc, out_data}, 64'd0);
    check("rst_full", ch_full, 3'b000);
    check("rst_ovf", ovf_flag, 3'b000);

    // two words on ch0, then prove cur_ch moved to 1
    out_ready = 1'b1;
    push(0, 32'hA1, 1'b0);
    check("lat_idle", out_valid, 1'b0);
    push(0, 32'hA2, 1'b1);
    check("lat_first", {out_valid, out_data}, {1'b1, 32'hA1});
    repeat (4) step();
    push(0, 32'hA3, 1'b1);
    push(1, 32'hB1, 1'b1);
    repeat (5) step();
    check("t1_n", q.size(), 3);
    check("t1_w0", q[0], {2'd0, 1'b0, 32'hA1});
    check("t1_w1", q[1], {2'd0, 1'b1, 32'hA2});
    check("t1_sw", q[2], {2'd1, 1'b1, 32'hB1});

    do_reset();
    out_ready = 1'b1;
    push(2, 32'hC1, 1'b1);
    push(1, 32'hB1, 1'b1);
    push(0, 32'hA1, 1'b1);
    repeat (6) step();
    check("ord_n", q.size(), 3);
    check("ord_0", q[0], {2'd0, 1'b1, 32'hA1});
    check("ord_1", q[1], {2'd1, 1'b1, 32'hB1});
    check("ord_2", q[2], {2'd2, 1'b1, 32'hC1});

    do_reset();
    push(0, 32'h10, 1'b0);
    push(0, 32'h11, 1'b0);
    push(0, 32'h12, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", {out_valid, out_eob, out_orc, out_data},
            {1'b1, 1'b0, 5'h10, 32'h10});
    end
    out_ready = 1'b1;
    repeat (5) step();
    check("bp_n", q.size(), 3);
    check("bp_0", q[0], {2'd0, 1'b0, 32'h10});
    check("bp_1", q[1], {2'd0, 1'b0, 32'h11});
    check("bp_2", q[2], {2'd0, 1'b1, 32'h12});

    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) push(1, 32'h100 + k, k == 15);
    check("ovf_full", ch_full, 3'b010);
    check("ovf_flag", ovf_flag, OVF_EXP);
    check("ovf_idle", out_valid, 1'b0);
    push(0, 32'hA0, 1'b1);
    repeat (25) step();
    check("ovf_n", q.size(), 17);
    check("ovf_a0", q[0], {2'd0, 1'b1, 32'hA0});
    for (int k = 0; k < 16; k++)
      check($sformatf("ovf_w%0d", k), q[k+1],
            {2'd1, (k == 15), 32'h100 + k});
    check("ovf_drained", ch_full, 3'b000);
    check("ovf_sticky", ovf_flag, OVF_EXP);

    do_reset();
    push(0, 32'h50, 1'b0);
    push(0, 32'h51, 1'b0);
    push(0, 32'h52, 1'b1);
    check("mid_busy", {out_valid, out_data}, {1'b1, 32'h50});
    rst = 1'b0;
    #1;
    check("mid_rst", {out_valid, out_eob, out_ch, out_orc, out_data}, 64'd0);
    check("mid_full", ch_full, 3'b000);
    repeat (2) step();
    q.delete();
    rst = 1'b1;
    step();
    out_ready = 1'b1;
    push(1, 32'hB5, 1'b1);
    push(0, 32'hA5, 1'b1);
    repeat (6) step();
    check("mid_n", q.size(), 2);
    check("mid_0", q[0], {2'd0, 1'b1, 32'hA5});
    check("mid_1", q[1], {2'd1, 1'b1, 32'hB5});

    // single-channel build at full rate
    do_reset();
    r1 = 1'b1;
    for (int k = 0; k < 130; k++) begin
      v1 = 1'b1;
      d1 = 32'(k);
      e1 = (k % 64) == 63;
      step();
    end
    v1 = 1'b0;
    e1 = 1'b0;
    repeat (5) step();
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < q1.size(); k++)
        if (q1[k] !== 32'(k)) bad++;
      check("nc1_n", q1.size(), 130);
      check("nc1_order", bad, 0);
    end
    check("nc1_ch", ch_bad, 0);
    check("nc1_rate", max_run, 130);
    check("nc1_full", full1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
